systolic_feeder: RTL and testbench

- Source side of the 3x3 systolic multiplier's operand interface.
- Holds matrices A and B in local register buffers, loaded one row per write.
- On `start`, clears the downstream array's accumulators, then streams one A column and one B row per cycle with a valid strobe.
- Then drives zero-flush cycles so the array drains, and signals `done`.
- Sits between the host/register interface and the array's matrix_a_in/matrix_b_in/valid_in inputs.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/feeder_row_buf.sv | 44 ++++
 rtl/systolic_feeder.sv | 149 ++++++++++++++
 tb/tb_systolic_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic multiplier operand feeder: defaults, feeder FSM states, row types.
package systolic_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int N_DEF         = 3;
   localparam int FLUSH_CYCLES  = 2 * N_DEF - 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_FLUSH,
      ST_DONE
   } feeder_state_e;

   typedef logic [DATA_SIZE_DEF-1:0]       elem_t;
   typedef logic [DATA_SIZE_DEF*N_DEF-1:0] row_t;

   // Zero-flush length needed to drain an n x n skewed array.
   function automatic int flush_cycles(input int n);
      return 2 * n - 2;
   endfunction

endpackage

// File: rtl/feeder_row_buf.sv
// NxN element buffer: one full row written per cycle, one row or one column read per step index.
module feeder_row_buf #(
   parameter int DATA_SIZE = 8,
   parameter int N         = 3,
   parameter bit COL_READ  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [$clog2(N)-1:0]   wr_row,
   input  logic [DATA_SIZE*N-1:0] wr_data,
   input  logic [$clog2(N)-1:0]   rd_k,
   output logic [DATA_SIZE*N-1:0] rd_data
);

   logic [DATA_SIZE-1:0] mem_q [N][N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else if (wr_en && (int'(wr_row) < N)) begin
         for (int c = 0; c < N; c++) begin
            mem_q[wr_row][c] <= wr_data[c*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   // Lane i gets mem[i][k] (column read) or mem[k][i] (row read).
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < N; i++) begin
         if (COL_READ) begin
            rd_data[i*DATA_SIZE +: DATA_SIZE] = mem_q[i][rd_k];
         end else begin
            rd_data[i*DATA_SIZE +: DATA_SIZE] = mem_q[rd_k][i];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the NxN systolic array: clear, stream N steps, zero-flush, done.
// Define FEEDER_B_TRANSPOSE_EN to store B column-wise (host loads B^T in row format).
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int N         = N_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [$clog2(N)-1:0]   wr_row,
   input  logic [DATA_SIZE*N-1:0] wr_data,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   array_reset,
   output logic [DATA_SIZE*N-1:0] matrix_a_out,
   output logic [DATA_SIZE*N-1:0] matrix_b_out,
   output logic                   valid_out
);

   localparam int KW      = $clog2(N);
   localparam int CW      = $clog2(2 * N);
   localparam int FLUSH_N = flush_cycles(N);
`ifdef FEEDER_B_TRANSPOSE_EN
   localparam bit B_COL_READ = 1'b1;
`else
   localparam bit B_COL_READ = 1'b0;
`endif

   feeder_state_e          state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   clr_q, clr_d;
   logic                   vld_q, vld_d;
   logic [DATA_SIZE*N-1:0] a_q, a_d;
   logic [DATA_SIZE*N-1:0] b_q, b_d;
   logic [DATA_SIZE*N-1:0] a_rd, b_rd;
   logic                   idle_wr;

   // Buffers are frozen from the first non-IDLE cycle until the run ends.
   assign idle_wr = wr_en && (state_q == ST_IDLE);

   feeder_row_buf #(.DATA_SIZE(DATA_SIZE), .N(N), .COL_READ(1'b1)) u_a_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (idle_wr && !wr_sel),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .rd_k    (cnt_d[KW-1:0]),
      .rd_data (a_rd)
   );

   feeder_row_buf #(.DATA_SIZE(DATA_SIZE), .N(N), .COL_READ(B_COL_READ)) u_b_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (idle_wr && wr_sel),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .rd_k    (cnt_d[KW-1:0]),
      .rd_data (b_rd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         vld_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         vld_q   <= vld_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_d = ST_STREAM;
            cnt_d   = '0;
         end
         ST_STREAM: begin
            if (cnt_q == CW'(N - 1)) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == CW'(FLUSH_N - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded from the next state so the registered copy lines up with state_q.
   always_comb begin
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      clr_d  = (state_d == ST_CLEAR);
      vld_d  = (state_d == ST_STREAM);
      a_d    = '0;
      b_d    = '0;
      if (state_d == ST_STREAM) begin
         a_d = a_rd;
         b_d = b_rd;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign array_reset  = clr_q;
   assign valid_out    = vld_q;
   assign matrix_a_out = a_q;
   assign matrix_b_out = b_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a timeline model of each run; honours FEEDER_B_TRANSPOSE_EN.
module tb_systolic_feeder;

   localparam int DW  = 8;
   localparam int N   = 3;
   localparam int RUN = 3 * N;

   logic          clk = 1'b0;
   logic          reset, wr_en, wr_sel, start;
   logic [1:0]    wr_row;
   logic [23:0]   wr_data;
   logic          busy, done, array_reset, valid_out;
   logic [23:0]   matrix_a_out, matrix_b_out;

   always #5 clk = ~clk;

   systolic_feeder #(.DATA_SIZE(DW), .N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_sel       (wr_sel),
      .wr_row       (wr_row),
      .wr_data      (wr_data),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .array_reset  (array_reset),
      .matrix_a_out (matrix_a_out),
      .matrix_b_out (matrix_b_out),
      .valid_out    (valid_out)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pk(input int e0, input int e1, input int e2);
      return {e2[7:0], e1[7:0], e0[7:0]};
   endfunction

   // Model: logical matrices A and B plus "cycles since start was accepted".
   int mA [N][N];
   int mB [N][N];
   int phase = 0;
   bit comparing = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         phase = 0;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               mA[r][c] = 0;
               mB[r][c] = 0;
            end
      end else if (phase == 0) begin
         if (wr_en && int'(wr_row) < N) begin
            for (int c = 0; c < N; c++) begin
               if (!wr_sel) mA[wr_row][c] = int'(wr_data[c*8 +: 8]);
`ifdef FEEDER_B_TRANSPOSE_EN
               else mB[c][wr_row] = int'(wr_data[c*8 +: 8]);
`else
               else mB[wr_row][c] = int'(wr_data[c*8 +: 8]);
`endif
            end
         end
         if (start) phase = 1;
      end else if (phase == RUN) begin
         phase = 0;
      end else begin
         phase++;
      end
   end

   always @(negedge clk) begin
      logic [23:0] ea, eb;
      int k;
      if (comparing) begin
         ea = '0;
         eb = '0;
         if (phase >= 2 && phase <= N + 1) begin
            k = phase - 2;
            for (int i = 0; i < N; i++) begin
               ea[i*8 +: 8] = 8'(mA[i][k]);
               eb[i*8 +: 8] = 8'(mB[k][i]);
            end
         end
         chk("m_busy",  busy,         phase != 0);
         chk("m_clear", array_reset,  phase == 1);
         chk("m_valid", valid_out,    phase >= 2 && phase <= N + 1);
         chk("m_done",  done,         phase == RUN);
         chk("m_a",     matrix_a_out, ea);
         chk("m_b",     matrix_b_out, eb);
      end
   end

   task automatic wr(input bit sel, input int row, input logic [23:0] d);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_row  = row[1:0];
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Pulse start; returns in the CLEAR cycle (d = 1).
   task automatic start_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   int dcnt;

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
      @(posedge clk);
      comparing = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_a",     matrix_a_out, 0);
      reset = 1'b0;

      // Load A = 1..9, B = I; an out-of-range row must be ignored.
      wr(0, 0, pk(1, 2, 3));
      wr(0, 1, pk(4, 5, 6));
      wr(0, 2, pk(7, 8, 9));
      wr(1, 0, pk(1, 0, 0));
      wr(1, 1, pk(0, 1, 0));
      wr(1, 2, pk(0, 0, 1));
      wr(1, 3, pk(255, 255, 255));

      // Run 1 with writes during STREAM and a start pulse while busy.
      start_run();
      dcnt = 0;
      for (int d = 1; d <= 12; d++) begin
         if (done) dcnt++;
         if (d == 1) chk("clr_t1", array_reset, 1);
         if (d == 2) begin
            chk("k0_a", matrix_a_out, pk(1, 4, 7));
            chk("k0_b", matrix_b_out, pk(1, 0, 0));
            chk("k0_valid", valid_out, 1);
         end
         if (d == 4) begin
            chk("k2_a", matrix_a_out, pk(3, 6, 9));
            chk("k2_b", matrix_b_out, pk(0, 0, 1));
         end
         if (d >= 5 && d <= 8) chk("flush_zero", {valid_out, matrix_a_out, matrix_b_out}, 0);
         if (d == 9) chk("done_t9", done, 1);
         if (d == 10) chk("busy_drop", busy, 0);
         wr_en   = (d == 2 || d == 3);
         wr_sel  = 1'b0;
         wr_row  = 2'd0;
         wr_data = '1;
         start   = (d == 5);
         @(negedge clk);
      end
      wr_en = 1'b0;
      start = 1'b0;
      chk("one_done", dcnt, 1);

      // Run 2 shows the original A.
      start_run();
      @(negedge clk);
      chk("rerun_a", matrix_a_out, pk(1, 4, 7));
      repeat (9) @(negedge clk);

      // B loaded with 1..9: row-wise or column-wise depending on build.
      wr(1, 0, pk(1, 2, 3));
      wr(1, 1, pk(4, 5, 6));
      wr(1, 2, pk(7, 8, 9));
      start_run();
      @(negedge clk);
`ifdef FEEDER_B_TRANSPOSE_EN
      chk("bt_k0", matrix_b_out, pk(1, 4, 7));
`else
      chk("b_k0", matrix_b_out, pk(1, 2, 3));
`endif
      repeat (9) @(negedge clk);

      // start and write in the same IDLE cycle: run uses the new row.
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = pk(9, 9, 9);
      start = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("start_wr_a", matrix_a_out, pk(9, 4, 7));
      repeat (9) @(negedge clk);

      // start held high: back-to-back runs.
      start = 1'b1;
      dcnt = 0;
      repeat (24) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      start = 1'b0;
      chk("held_dones", dcnt, 2);
      repeat (12) @(negedge clk);

      // Reset mid-run.
      start_run();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_out", {busy, done, array_reset, valid_out, matrix_a_out, matrix_b_out}, 0);
      dcnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      start_run();
      @(negedge clk);
      chk("post_rst_valid", valid_out, 1);
      chk("post_rst_a", matrix_a_out, 0);
      repeat (10) @(negedge clk);

      comparing = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
